// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - fixed-latency word-addressed RAM responder for memory_control
module ram_responder #(
    parameter int ADDR_W = 14,
    parameter int LAT    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        ramREN,
    input  logic        ramWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    ramstate_t         r_state;
    ramstate_t         w_next_state;
    ramstate_t         w_new_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic              r_wr;
    logic [31:0]       r_load;
    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

    logic              w_req;
    logic              w_illegal;
    logic              w_changed;
    logic              w_latch;
    logic              w_load_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_rd_idx;

    assign w_req     = ramREN | ramWEN;
    assign w_illegal = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
                     | ((ramaddr >> (ADDR_W + 2)) != 32'd0);
    // Any deviation from the latched request while waiting restarts the access.
    assign w_changed = ~w_req | (ramREN & ramWEN) | (ramWEN != r_wr)
                     | (ramaddr != r_addr) | (r_wr & (ramstore != r_data));
    assign w_rd_idx  = w_latch ? ramaddr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];

    always_comb begin
        if (w_illegal) begin
            w_new_state = ERROR;
        end else if (LAT_C == 4'd0) begin
            w_new_state = ACCESS;
        end else begin
            w_new_state = BUSY;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        w_load_en    = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            FREE: begin
                if (w_req) begin
                    w_next_state = w_new_state;
                    w_next_cnt   = LAT_C;
                    w_latch      = ~w_illegal;
                    w_load_en    = ~w_illegal & (LAT_C == 4'd0) & ~ramWEN;
                end
            end
            BUSY: begin
                if (w_changed) begin
                    if (w_req) begin
                        w_next_state = w_new_state;
                        w_next_cnt   = LAT_C;
                        w_latch      = ~w_illegal;
                        w_load_en    = ~w_illegal & (LAT_C == 4'd0) & ~ramWEN;
                    end else begin
                        w_next_state = FREE;
                    end
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_next_state = ACCESS;
                        w_load_en    = ~r_wr;
                    end
                end
            end
            ACCESS: begin
                w_next_state = FREE;
                w_mem_we     = r_wr;
            end
            ERROR: begin
                if (!w_req) begin
                    w_next_state = FREE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FREE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_latch) begin
                r_addr <= ramaddr;
                r_data <= ramstore;
                r_wr   <= ramWEN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_load <= 32'd0;
        end else if (w_load_en) begin
            r_load <= r_mem[w_rd_idx];
        end
    end

    // Array has no reset; a write in flight when RST arrives is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && w_mem_we) begin
            r_mem[r_addr[ADDR_W+1:2]] <= r_data;
        end
    end

    assign ramload  = r_load;
    assign ramstate = r_state;
endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed and randomized self-checking bench for ram_responder
module tb_ram_responder;
    localparam logic [31:0] S_FREE   = 32'd0;
    localparam logic [31:0] S_BUSY   = 32'd1;
    localparam logic [31:0] S_ACCESS = 32'd2;
    localparam logic [31:0] S_ERROR  = 32'd3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic        sel;
    logic [31:0] addr, store;
    logic        ren, wen;

    logic [31:0] addr2, store2, addr0, store0;
    logic        ren2, wen2, ren0, wen0;
    logic [31:0] load2, load0;
    logic [1:0]  state2, state0;

    assign addr2  = sel ? 32'd0 : addr;
    assign store2 = sel ? 32'd0 : store;
    assign ren2   = sel ? 1'b0 : ren;
    assign wen2   = sel ? 1'b0 : wen;
    assign addr0  = sel ? addr : 32'd0;
    assign store0 = sel ? store : 32'd0;
    assign ren0   = sel ? ren : 1'b0;
    assign wen0   = sel ? wen : 1'b0;

    ram_responder #(.ADDR_W(14), .LAT(2)) dut2 (
        .CLK(CLK), .RST(RST), .ramaddr(addr2), .ramstore(store2),
        .ramREN(ren2), .ramWEN(wen2), .ramload(load2), .ramstate(state2)
    );

    ram_responder #(.ADDR_W(14), .LAT(0)) dut0 (
        .CLK(CLK), .RST(RST), .ramaddr(addr0), .ramstore(store0),
        .ramREN(ren0), .ramWEN(wen0), .ramload(load0), .ramstate(state0)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [logic [31:0]];
    logic [31:0] exp_load [2];
    logic [31:0] wq2 [$];
    logic [31:0] wq0 [$];

    function automatic logic [31:0] key(input logic s, input logic [31:0] a);
        return {s, 17'd0, a[15:2]};
    endfunction

    function automatic logic [31:0] cur_state();
        return sel ? {30'd0, state0} : {30'd0, state2};
    endfunction

    function automatic logic [31:0] cur_load();
        return sel ? load0 : load2;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input string tag);
        int lat;
        lat = sel ? 0 : 2;
        chk({tag, ":pre_free"}, cur_state(), S_FREE);
        addr = a; store = d; wen = w; ren = ~w;
        for (int i = 0; i < lat; i++) begin
            step();
            chk({tag, ":busy"}, cur_state(), S_BUSY);
        end
        step();
        chk({tag, ":access"}, cur_state(), S_ACCESS);
        if (!w) exp_load[sel] = model[key(sel, a)];
        chk({tag, ":load_access"}, cur_load(), exp_load[sel]);
        ren = 1'b0; wen = 1'b0;
        step();
        if (w) begin
            model[key(sel, a)] = d;
            if (sel) wq0.push_back(a); else wq2.push_back(a);
        end
        chk({tag, ":post_free"}, cur_state(), S_FREE);
        chk({tag, ":load_hold"}, cur_load(), exp_load[sel]);
    endtask

    task automatic do_illegal(input logic [31:0] a, input logic r, input logic w,
                              input logic [31:0] d, input int hold, input string tag);
        chk({tag, ":pre_free"}, cur_state(), S_FREE);
        addr = a; ren = r; wen = w; store = d;
        step();
        chk({tag, ":error"}, cur_state(), S_ERROR);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ":error_held"}, cur_state(), S_ERROR);
        end
        chk({tag, ":load_err"}, cur_load(), exp_load[sel]);
        ren = 1'b0; wen = 1'b0;
        step();
        chk({tag, ":free"}, cur_state(), S_FREE);
        chk({tag, ":load_free"}, cur_load(), exp_load[sel]);
    endtask

    initial begin : main
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic        r, w;

        RST = 1'b1; sel = 1'b0; addr = 32'd0; store = 32'd0; ren = 1'b0; wen = 1'b0;
        exp_load[0] = 32'd0; exp_load[1] = 32'd0;

        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_state2", {30'd0, state2}, S_FREE);
            chk("rst_load2", load2, 32'd0);
            chk("rst_state0", {30'd0, state0}, S_FREE);
            chk("rst_load0", load0, 32'd0);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_state2", {30'd0, state2}, S_FREE);
            chk("idle_load2", load2, 32'd0);
            chk("idle_state0", {30'd0, state0}, S_FREE);
        end

        do_access(1'b1, 32'h40, 32'hDEADBEEF, "t2_wr");
        do_access(1'b0, 32'h40, 32'd0, "t2_rd");

        do_access(1'b1, 32'h100, 32'h11111111, "t3_wr");
        addr = 32'h100; ren = 1'b1; wen = 1'b0;
        step(); chk("t3_busy1", cur_state(), S_BUSY);
        step(); chk("t3_busy2", cur_state(), S_BUSY);
        addr = 32'h40;
        step(); chk("t3_busy3", cur_state(), S_BUSY);
        chk("t3_load_busy", cur_load(), exp_load[0]);
        step(); chk("t3_busy4", cur_state(), S_BUSY);
        step(); chk("t3_access", cur_state(), S_ACCESS);
        exp_load[0] = model[key(0, 32'h40)];
        chk("t3_load", cur_load(), exp_load[0]);
        ren = 1'b0;
        step(); chk("t3_free", cur_state(), S_FREE);

        do_illegal(32'h42, 1'b1, 1'b0, 32'd0, 2, "t4_misalign");
        do_illegal(32'h40000, 1'b1, 1'b0, 32'd0, 1, "t4_range");
        do_illegal(32'h40, 1'b1, 1'b1, 32'h0BAD0BAD, 0, "t4_both");
        do_access(1'b0, 32'h40, 32'd0, "t4_rd");

        addr = 32'h44; store = 32'h1; wen = 1'b1; ren = 1'b0;
        step(); chk("wd_busy1", cur_state(), S_BUSY);
        store = 32'h2;
        step(); chk("wd_busy2", cur_state(), S_BUSY);
        step(); chk("wd_busy3", cur_state(), S_BUSY);
        step(); chk("wd_access", cur_state(), S_ACCESS);
        wen = 1'b0;
        step(); chk("wd_free", cur_state(), S_FREE);
        model[key(0, 32'h44)] = 32'h2;
        wq2.push_back(32'h44);
        do_access(1'b0, 32'h44, 32'd0, "wd_rd");

        do_access(1'b1, 32'h80, 32'hCAFEF00D, "t5_wr0");
        addr = 32'h80; store = 32'h12345678; wen = 1'b1;
        step(); chk("t5_busy", cur_state(), S_BUSY);
        RST = 1'b1; wen = 1'b0;
        step();
        chk("t5_rst_state", cur_state(), S_FREE);
        chk("t5_rst_load", cur_load(), 32'd0);
        RST = 1'b0;
        exp_load[0] = 32'd0; exp_load[1] = 32'd0;
        step(); chk("t5_free", cur_state(), S_FREE);
        do_access(1'b0, 32'h80, 32'd0, "t5_rd");

        sel = 1'b1;
        step();
        do_access(1'b1, 32'h40, 32'hDEADBEEF, "t6_wr");
        do_access(1'b0, 32'h40, 32'd0, "t6_rd1");
        do_access(1'b0, 32'h40, 32'd0, "t6_rd2");
        addr = 32'h40; ren = 1'b1;
        step(); chk("t6_held_acc1", cur_state(), S_ACCESS);
        chk("t6_held_load", cur_load(), 32'hDEADBEEF);
        step(); chk("t6_held_free", cur_state(), S_FREE);
        step(); chk("t6_held_acc2", cur_state(), S_ACCESS);
        ren = 1'b0;
        step(); chk("t6_held_end", cur_state(), S_FREE);

        for (int it = 0; it < 60; it++) begin
            sel = 1'($urandom_range(0, 1));
            step();
            kind = int'($urandom_range(0, 3));
            if (kind == 1 || kind == 2) begin
                if (sel && wq0.size() > 0) begin
                    a = wq0[$urandom_range(0, wq0.size() - 1)];
                    do_access(1'b0, a, 32'd0, "rnd_rd");
                end else if (!sel && wq2.size() > 0) begin
                    a = wq2[$urandom_range(0, wq2.size() - 1)];
                    do_access(1'b0, a, 32'd0, "rnd_rd");
                end else begin
                    kind = 0;
                end
            end
            if (kind == 0) begin
                a = 32'($urandom_range(0, 31)) << 2;
                d = $urandom;
                do_access(1'b1, a, d, "rnd_wr");
            end else if (kind == 3) begin
                r = 1'b1; w = 1'b0;
                case ($urandom_range(0, 2))
                    0: begin
                        a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
                        w = 1'($urandom_range(0, 1)); r = ~w;
                    end
                    1: begin
                        a = 32'h1 << $urandom_range(16, 31);
                        w = 1'($urandom_range(0, 1)); r = ~w;
                    end
                    default: begin
                        a = 32'($urandom_range(0, 31)) << 2;
                        w = 1'b1;
                    end
                endcase
                do_illegal(a, r, w, $urandom, int'($urandom_range(0, 2)), "rnd_ill");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
